// File: rtl/input_conditioner.sv
// Per-bit synchronizer + debouncer for async lines; emits a stable level plus one-cycle edge pulses.
// Latency: a held input step appears on o_q SYNC_STAGES+DB_CNT edges after it is first sampled.
module input_conditioner #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_chg
);

  localparam int            CW   = $clog2(DB_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CNT - 1);

  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [CW-1:0]    cnt  [WIDTH];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] flip;

  assign s = sync[SYNC_STAGES-1];

  // A bit flips once it has disagreed with o_q for DB_CNT consecutive edges.
  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip[i] = (s[i] != o_q[i]) && (cnt[i] == LAST);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      o_q    <= '0;
      o_rise <= '0;
      o_fall <= '0;
    end else begin
      sync[0] <= i_d;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == o_q[i] || cnt[i] == LAST) cnt[i] <= '0;
        else                                  cnt[i] <= cnt[i] + CW'(1);
      end
      o_q    <= o_q ^ flip;
      o_rise <= flip & ~o_q;
      o_fall <= flip & o_q;
    end
  end

  assign o_chg = |(o_rise | o_fall);

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: default instance (latency 6) plus a DB_CNT=1/SYNC_STAGES=3 instance (latency 4).
module tb_input_conditioner;

  localparam int L1 = 6;
  localparam int L2 = 4;

  logic       clk;
  logic       rst;
  logic [3:0] d, d2;
  logic [3:0] q, rise, fall, q2, rise2, fall2;
  logic       chg, chg2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] q, r, f, q2, r2, f2;
  } exp_t;

  exp_t  sb [$];
  string tq [$];

  input_conditioner dut (
    .i_clk(clk), .i_rst(rst), .i_d(d),
    .o_q(q), .o_rise(rise), .o_fall(fall), .o_chg(chg)
  );

  input_conditioner #(.WIDTH(4), .SYNC_STAGES(3), .DB_CNT(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_d(d2),
    .o_q(q2), .o_rise(rise2), .o_fall(fall2), .o_chg(chg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the expectation is for the next rising edge.
  task automatic step(input logic [3:0] dv, input logic [3:0] d2v, input logic rv,
                      input logic [3:0] q1, input logic [3:0] r1, input logic [3:0] f1,
                      input logic [3:0] qb, input logic [3:0] rb, input logic [3:0] fb,
                      input string tag);
    exp_t e;
    @(negedge clk);
    d   = dv;
    d2  = d2v;
    rst = rv;
    e.q = q1; e.r = r1; e.f = f1;
    e.q2 = qb; e.r2 = rb; e.f2 = fb;
    sb.push_back(e);
    tq.push_back(tag);
  endtask

  // Hold inputs for n edges starting from a settled state (o1/o2 -> n1/n2).
  task automatic hold(input logic [3:0] dv, input logic [3:0] d2v, input int n,
                      input logic [3:0] o1, input logic [3:0] n1,
                      input logic [3:0] o2, input logic [3:0] n2, input string tag);
    for (int k = 1; k <= n; k++) begin
      step(dv, d2v, 1'b0,
           (k >= L1) ? n1 : o1, (k == L1) ? (n1 & ~o1) : 4'h0, (k == L1) ? (o1 & ~n1) : 4'h0,
           (k >= L2) ? n2 : o2, (k == L2) ? (n2 & ~o2) : 4'h0, (k == L2) ? (o2 & ~n2) : 4'h0,
           tag);
    end
  endtask

  task automatic rst_steps(input logic [3:0] dv, input logic [3:0] d2v, input int n);
    for (int k = 0; k < n; k++)
      step(dv, d2v, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "reset");
  endtask

  exp_t  me;
  string mt;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      me = sb.pop_front();
      mt = tq.pop_front();
      check_eq({mt, ".q"},     32'(q),     32'(me.q));
      check_eq({mt, ".rise"},  32'(rise),  32'(me.r));
      check_eq({mt, ".fall"},  32'(fall),  32'(me.f));
      check_eq({mt, ".chg"},   32'(chg),   32'(|(me.r | me.f)));
      check_eq({mt, ".q2"},    32'(q2),    32'(me.q2));
      check_eq({mt, ".rise2"}, 32'(rise2), 32'(me.r2));
      check_eq({mt, ".fall2"}, 32'(fall2), 32'(me.f2));
      check_eq({mt, ".chg2"},  32'(chg2),  32'(|(me.r2 | me.f2)));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    d   = 4'h0;
    d2  = 4'h0;
    rst = 1'b1;

    rst_steps(4'hF, 4'h0, 3);
    hold(4'hF, 4'h0, 8, 4'h0, 4'hF, 4'h0, 4'h0, "release");

    rst_steps(4'h0, 4'h0, 1);
    hold(4'h5, 4'h0, 8, 4'h0, 4'h5, 4'h0, 4'h0, "step_up");
    hold(4'hA, 4'h0, 8, 4'h5, 4'hA, 4'h0, 4'h0, "swap");
    hold(4'h0, 4'h0, 8, 4'hA, 4'h0, 4'h0, 4'h0, "step_dn");

    // Three-cycle pulse on bit0 must be rejected.
    hold(4'h1, 4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0, "glitch3");
    hold(4'h0, 4'h0, 6, 4'h0, 4'h0, 4'h0, 4'h0, "glitch3_tail");

    // Four-cycle pulse on bit0 is just long enough, then decays back.
    for (int k = 1; k <= 12; k++)
      step((k <= 4) ? 4'h1 : 4'h0, 4'h0, 1'b0,
           (k >= 6 && k < 10) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0, (k == 10) ? 4'h1 : 4'h0,
           4'h0, 4'h0, 4'h0, "glitch4");

    // Bit2 bounces 1,0,1,1,0 then settles high; last toggle is at step 6.
    for (int k = 1; k <= 14; k++) begin
      logic [3:0] bv;
      case (k)
        1, 3, 4: bv = 4'h4;
        2, 5:    bv = 4'h0;
        default: bv = 4'h4;
      endcase
      step(bv, 4'h0, 1'b0,
           (k >= 11) ? 4'h4 : 4'h0, (k == 11) ? 4'h4 : 4'h0, 4'h0,
           4'h0, 4'h0, 4'h0, "bounce");
    end

    // Reset arriving mid-count discards progress.
    rst_steps(4'h0, 4'h0, 1);
    hold(4'h8, 4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0, "mid_pre");
    rst_steps(4'h8, 4'h0, 1);
    hold(4'h8, 4'h0, 8, 4'h0, 4'h8, 4'h0, 4'h0, "mid_post");

    // Reset landing on a terminal count still wins.
    rst_steps(4'h0, 4'h0, 1);
    hold(4'h3, 4'h0, 5, 4'h0, 4'h0, 4'h0, 4'h0, "term_pre");
    rst_steps(4'h3, 4'h0, 1);

    hold(4'h0, 4'hA, 6, 4'h0, 4'h0, 4'h0, 4'hA, "corner_up");
    hold(4'h0, 4'h0, 6, 4'h0, 4'h0, 4'hA, 4'h0, "corner_dn");

    @(posedge clk);
    #2;
    check_eq("drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
